// File: rtl/spi_mem_arbiter.sv
// Round-robin arbiter that shares one SPI memory command port between NUM_REQ requesters.
// A granted command is held on mem_* until mem_done or timeout, then returned to its owner.
module spi_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_din,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_dout,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      mem_valid,
    output logic                      mem_wr,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout,
    input  logic                      mem_done,
    input  logic                      mem_err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state;
    logic [PTR_W-1:0]  last;
    logic [CNT_W-1:0]  cnt;
    int                sel_idx;
    logic [PTR_W-1:0]  sel;
    logic              tmo_hit;
    logic              finish;

    // First asserted request scanning upward from the one after the last winner.
    always_comb begin
        sel_idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_REQ]) begin
                sel_idx = (int'(last) + k) % NUM_REQ;
            end
        end
    end

    assign sel     = PTR_W'(sel_idx);
    assign tmo_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign finish  = mem_done || tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= PTR_W'(NUM_REQ - 1);
            cnt       <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_dout  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            mem_valid <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt       <= '0;
                    rsp_valid <= '0;
                    if (|req) begin
                        gnt       <= NUM_REQ'(1) << sel;
                        mem_valid <= 1'b1;
                        mem_wr    <= req_wr[sel];
                        mem_addr  <= req_addr[sel_idx*ADDR_W +: ADDR_W];
                        mem_din   <= req_din[sel_idx*DATA_W +: DATA_W];
                        last      <= sel;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    gnt <= '0;
                    // A completion on the same edge as the timeout takes precedence.
                    if (finish) begin
                        rsp_dout  <= mem_done ? mem_dout : '0;
                        rsp_err   <= mem_done ? mem_err : 1'b1;
                        rsp_valid <= NUM_REQ'(1) << last;
                        mem_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    cnt       <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed and randomized bench for spi_mem_arbiter against a transaction-level round-robin model.
module tb_spi_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req, req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_din;
    logic [N-1:0]  gnt, rsp_valid, gnt_t, rsp_valid_t;
    logic [DW-1:0] rsp_dout, rsp_dout_t, mem_din, mem_din_t, mem_dout, mem_dout_t;
    logic [AW-1:0] mem_addr, mem_addr_t;
    logic          rsp_err, busy, mem_valid, mem_wr, mem_done, mem_err;
    logic          rsp_err_t, busy_t, mem_valid_t, mem_wr_t, mem_done_t, mem_err_t;

    int checks = 0;
    int failures = 0;
    int last_m;

    spi_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(1024)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout), .rsp_err(rsp_err), .busy(busy),
        .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_done(mem_done), .mem_err(mem_err)
    );

    spi_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_din(req_din),
        .gnt(gnt_t), .rsp_valid(rsp_valid_t), .rsp_dout(rsp_dout_t), .rsp_err(rsp_err_t),
        .busy(busy_t), .mem_valid(mem_valid_t), .mem_wr(mem_wr_t), .mem_addr(mem_addr_t),
        .mem_din(mem_din_t), .mem_dout(mem_dout_t), .mem_done(mem_done_t), .mem_err(mem_err_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first requester set, looking from last+1 upward, modulo N.
    function automatic int rr_pick(input logic [N-1:0] m, input int from);
        for (int k = 1; k <= N; k++) begin
            if (m[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        mem_done = 1'b0; mem_err = 1'b0; mem_dout = '0;
        mem_done_t = 1'b0; mem_err_t = 1'b0; mem_dout_t = '0;
        tick();
        tick();
        rst = 1'b0;
        last_m = N - 1;
    endtask

    // One full transaction on the main DUT, called with the DUT idle and req already driven.
    task automatic run_txn(input int dly, input logic [DW-1:0] dout, input logic err, input bit drop);
        int s;
        logic ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        s  = rr_pick(req, last_m);
        ew = req_wr[s];
        ea = req_addr[s*AW +: AW];
        ed = req_din[s*DW +: DW];
        tick();
        chk("gnt", 32'(gnt), 32'(1) << s);
        chk("mem_valid_start", 32'(mem_valid), 32'd1);
        chk("mem_wr", 32'(mem_wr), 32'(ew));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_din", 32'(mem_din), 32'(ed));
        chk("busy_start", 32'(busy), 32'd1);
        last_m = s;
        if (drop) req[s] = 1'b0;
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("gnt_pulse", 32'(gnt), 32'd0);
            chk("hold", {mem_valid, 7'd0, mem_wr, 7'd0, mem_addr, mem_din}, {1'b1, 7'd0, ew, 7'd0, ea, ed});
            chk("no_early_rsp", 32'(rsp_valid), 32'd0);
        end
        mem_dout = dout; mem_err = err; mem_done = 1'b1;
        tick();
        mem_done = 1'b0; mem_err = 1'b0; mem_dout = '0;
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << s);
        chk("rsp_dout", 32'(rsp_dout), 32'(dout));
        chk("rsp_err", 32'(rsp_err), 32'(err));
        chk("mem_valid_resp", 32'(mem_valid), 32'd0);
        tick();
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
        chk("idle_gap", {30'd0, busy, |gnt}, 32'd0);
        chk("rsp_hold", {23'd0, rsp_err, rsp_dout}, {23'd0, err, dout});
    endtask

    initial begin
        logic [N-1:0] nm;
        req = '0; req_wr = '0; req_addr = '0; req_din = '0;
        do_reset();
        chk("reset_outputs", {gnt, rsp_valid, rsp_dout, 5'd0, rsp_err, busy, mem_valid, mem_wr},
            32'd0);
        chk("reset_mem", {16'd0, mem_addr, mem_din}, 32'd0);

        // Single write from requester 2
        req_wr[2] = 1'b1; req_addr[2*AW +: AW] = 8'h10; req_din[2*DW +: DW] = 8'hA5;
        req = 4'b0100;
        run_txn(20, 8'h00, 1'b0, 1'b1);

        // All requesters held high: strict rotation starting at 0
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            chk("rr_order", 32'(rr_pick(req, last_m)), 32'(t % N));
            run_txn(5, 8'(t + 1), 1'b0, 1'b0);
        end
        req = '0;

        // Read from requester 1, then error completion for requester 3
        req_wr[1] = 1'b0; req_addr[1*AW +: AW] = 8'h22;
        req = 4'b0010;
        run_txn(3, 8'h5A, 1'b0, 1'b1);
        req_wr[3] = 1'b0; req_addr[3*AW +: AW] = 8'h33;
        req = 4'b1000;
        run_txn(2, 8'h33, 1'b1, 1'b1);

        // Stray mem_done while idle
        mem_done = 1'b1; mem_dout = 8'hEE;
        tick();
        mem_done = 1'b0;
        chk("idle_done_rsp", 32'(rsp_valid), 32'd0);
        chk("idle_done_busy", 32'(busy), 32'd0);
        tick();
        chk("idle_done_rsp2", 32'(rsp_valid), 32'd0);
        chk("idle_done_dout", 32'(rsp_dout), 32'h33);

        // Randomized traffic with pending requests accumulating
        for (int t = 0; t < 40; t++) begin
            nm = N'($urandom_range(0, 15));
            if ((req | nm) == '0) nm[$urandom_range(0, N - 1)] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!req[i] && nm[i]) begin
                    req_wr[i] = 1'($urandom);
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_din[i*DW +: DW] = DW'($urandom);
                end
            end
            req = req | nm;
            run_txn(int'($urandom_range(0, 12)), DW'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
        end
        req = '0;

        // Timeout instance: done coinciding with the timeout edge wins
        do_reset();
        req = 4'b0001;
        tick();
        chk("to_gnt", 32'(gnt_t), 32'b0001);
        req = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_wait", 32'(rsp_valid_t), 32'd0);
        end
        mem_done_t = 1'b1; mem_err_t = 1'b0; mem_dout_t = 8'hC3;
        tick();
        mem_done_t = 1'b0; mem_dout_t = '0;
        chk("to_same_edge", {22'd0, rsp_valid_t, rsp_err_t, 1'b0, rsp_dout_t}, {22'd0, 4'b0001, 1'b0, 1'b0, 8'hC3});
        tick();
        chk("to_idle", 32'(busy_t), 32'd0);

        // Pure timeout: 16 BUSY cycles, then forced error response
        req = 4'b0010;
        tick();
        chk("to_gnt2", 32'(gnt_t), 32'b0010);
        req = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("to_wait2", 32'(rsp_valid_t), 32'd0);
        end
        tick();
        chk("to_fire", {22'd0, rsp_valid_t, rsp_err_t, 1'b0, rsp_dout_t}, {22'd0, 4'b0010, 1'b1, 1'b0, 8'h00});
        tick();
        chk("to_pulse", 32'(rsp_valid_t), 32'd0);

        // Asynchronous reset in the middle of a transaction
        do_reset();
        req_wr[0] = 1'b1; req_addr[0*AW +: AW] = 8'h44; req_din[0*DW +: DW] = 8'h99;
        req = 4'b0001;
        run_txn(1, 8'h7E, 1'b1, 1'b1);
        req_wr[2] = 1'b1; req = 4'b0100;
        tick();
        chk("mid_gnt", 32'(gnt), 32'b0100);
        req = '0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {gnt, rsp_valid, rsp_dout, 5'd0, rsp_err, busy, mem_valid, mem_wr}, 32'd0);
        chk("async_rst_mem", {16'd0, mem_addr, mem_din}, 32'd0);
        tick();
        chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        last_m = N - 1;
        req = 4'b1010;
        chk("post_rst_pick", 32'(rr_pick(req, last_m)), 32'd1);
        run_txn(4, 8'h11, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
